// File: rtl/sw_debounce_capture.sv
// Debounces a bank of raw board switches on a shared sample tick and captures
// sticky rise/fall event flags with a registered, per-bit-enabled interrupt.
module sw_debounce_capture #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_sw,
    input  logic [WIDTH-1:0] i_clr_rise,
    input  logic [WIDTH-1:0] i_clr_fall,
    input  logic [WIDTH-1:0] i_irq_en,
    output logic [WIDTH-1:0] o_state,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic             o_irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0] CNT_LAST = 4'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [3:0]       cnt_q [WIDTH];
    logic [3:0]       cnt_d [WIDTH];
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             irq_q, irq_d;
    logic             tick;

    assign tick = (presc_q == PRESC_MAX);

    always_comb begin
        sync1_d = i_sw;
        sync2_d = sync1_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        state_d = state_q;
        for (int n = 0; n < WIDTH; n++) begin
            cnt_d[n] = cnt_q[n];
            // Any agreement between input and accepted level restarts the count.
            if (sync2_q[n] == state_q[n]) begin
                cnt_d[n] = 4'd0;
            end else if (tick) begin
                if (cnt_q[n] == CNT_LAST) begin
                    state_d[n] = sync2_q[n];
                    cnt_d[n]   = 4'd0;
                end else begin
                    cnt_d[n] = cnt_q[n] + 4'd1;
                end
            end
        end
        // Set wins over a coincident clear.
        rise_d = (rise_q & ~i_clr_rise) | (state_d & ~state_q);
        fall_d = (fall_q & ~i_clr_fall) | (~state_d & state_q);
        irq_d  = |((rise_q | fall_q) & i_irq_en);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
            state_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            irq_q   <= 1'b0;
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= 4'd0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= irq_d;
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign o_state = state_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_irq   = irq_q;

endmodule

// File: tb/tb_sw_debounce_capture.sv
// Directed bench for sw_debounce_capture: a cycle-level behavioural model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_sw_debounce_capture;

  localparam int W  = 16;
  localparam int TD = 4;
  localparam int ST = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] sw, clr_rise, clr_fall, irq_en;
  logic [W-1:0] o_state, o_rise, o_fall;
  logic         o_irq;

  sw_debounce_capture #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .i_clk(clk), .i_rst(rst), .i_sw(sw), .i_clr_rise(clr_rise),
    .i_clr_fall(clr_fall), .i_irq_en(irq_en), .o_state(o_state),
    .o_rise(o_rise), .o_fall(o_fall), .o_irq(o_irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: input history, cycles since reset, ticks-since-match per bit.
  logic [W-1:0] m_h1, m_h2, m_state, m_rise, m_fall, m_nstate;
  logic         m_irq, m_tick;
  int           m_cyc;
  int           m_mt [W];

  always @(posedge clk) begin
    if (rst) begin
      m_h1 = '0; m_h2 = '0; m_state = '0; m_rise = '0; m_fall = '0; m_irq = 1'b0;
      m_cyc = 0;
      for (int n = 0; n < W; n++) m_mt[n] = 0;
    end else begin
      m_tick = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      m_nstate = m_state;
      for (int n = 0; n < W; n++) begin
        if (m_h2[n] == m_state[n]) m_mt[n] = 0;
        else if (m_tick) begin
          m_mt[n]++;
          if (m_mt[n] >= ST) begin
            m_nstate[n] = m_h2[n];
            m_mt[n] = 0;
          end
        end
      end
      m_irq   = |((m_rise | m_fall) & irq_en);
      m_rise  = (m_rise & ~clr_rise) | (m_nstate & ~m_state);
      m_fall  = (m_fall & ~clr_fall) | (~m_nstate & m_state);
      m_state = m_nstate;
      m_h2    = m_h1;
      m_h1    = sw;
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    chk("model_state", 32'(o_state), 32'(m_state));
    chk("model_rise",  32'(o_rise),  32'(m_rise));
    chk("model_fall",  32'(o_fall),  32'(m_fall));
    chk("model_irq",   32'(o_irq),   32'(m_irq));
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [W-1:0] sw_val);
    rst = 1'b1;
    sw  = sw_val;
    step(2);
    rst = 1'b0;
  endtask

  logic [W-1:0] bounce_val [8] = '{16'h0100, 16'h0000, 16'h0100, 16'h0000,
                                   16'h0101, 16'h0001, 16'h0301, 16'h0201};
  int           bounce_len [8] = '{3, 2, 5, 1, 16, 9, 2, 20};

  initial begin
    sw = '0; clr_rise = '0; clr_fall = '0; irq_en = 16'h0001;
    step(3);
    chk("reset_state", 32'(o_state), 32'h0);
    chk("reset_flags", 32'({o_rise, o_fall}), 32'h0);
    chk("reset_irq",   32'(o_irq), 32'h0);

    // held-high input after release: accepted on the 12th edge
    do_reset(16'h0001);
    step(11);
    chk("hold_before_accept", 32'(o_state), 32'h0);
    step(1);
    chk("hold_state", 32'(o_state), 32'h1);
    chk("hold_rise",  32'(o_rise),  32'h1);
    chk("hold_fall",  32'(o_fall),  32'h0);
    step(1);
    chk("irq_asserted", 32'(o_irq), 32'h1);

    // write-1-to-clear, irq follows one cycle later
    clr_rise = 16'h0001;
    step(1);
    clr_rise = '0;
    chk("clr_rise_cleared", 32'(o_rise), 32'h0);
    chk("irq_lags_clear",   32'(o_irq),  32'h1);
    step(1);
    chk("irq_dropped", 32'(o_irq), 32'h0);

    // short glitch on bit 3 is discarded
    sw = 16'h0009;
    step(6);
    sw = 16'h0001;
    step(20);
    chk("glitch_state", 32'(o_state), 32'h1);
    chk("glitch_flags", 32'({o_rise, o_fall}), 32'h0);

    // clear coincident with set keeps the flag
    do_reset(16'h0020);
    step(11);
    clr_rise = 16'h0020;
    step(1);
    clr_rise = '0;
    chk("set_prio_state", 32'(o_state), 32'h20);
    chk("set_prio_rise",  32'(o_rise),  32'h20);
    step(1);
    chk("set_prio_hold",  32'(o_rise),  32'h20);

    // multi-bit swap
    sw = 16'h00FF;
    step(20);
    clr_rise = 16'hFFFF; clr_fall = 16'hFFFF;
    step(1);
    clr_rise = '0; clr_fall = '0;
    sw = 16'hFF00;
    step(20);
    chk("swap_state", 32'(o_state), 32'hFF00);
    chk("swap_rise",  32'(o_rise),  32'hFF00);
    chk("swap_fall",  32'(o_fall),  32'h00FF);

    // reset mid-debounce abandons the count
    do_reset(16'h0001);
    step(8);
    rst = 1'b1;
    step(1);
    chk("midreset_outputs", 32'({o_state, o_rise}), 32'h0);
    chk("midreset_fall",    32'({o_fall, 15'h0, o_irq}), 32'h0);
    rst = 1'b0;
    step(11);
    chk("midreset_not_yet", 32'(o_state), 32'h0);
    step(1);
    chk("midreset_accept",  32'(o_state), 32'h1);
    chk("midreset_rise",    32'(o_rise),  32'h1);

    // bouncy sequence, checked by the model
    irq_en = 16'h0300;
    for (int i = 0; i < 8; i++) begin
      sw = bounce_val[i];
      step(bounce_len[i]);
    end
    clr_fall = 16'hFFFF;
    step(2);
    clr_fall = '0;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
